// File: rtl/button_click_classifier.sv
// Groups debounced button pulses into click events (single, double, ... up to
// MAX_CLICKS). A group stays open while consecutive pulses are no more than
// WINDOW_TICKS cycles apart. Each closed group is offered as a click count
// over a valid/ready handshake. Pulses that arrive while an event waits for
// the consumer are discarded, and out_dropped reports them.
module button_click_classifier #(
  parameter int unsigned WINDOW_TICKS = 1000,
  parameter int unsigned WINDOW_BITS  = $clog2(WINDOW_TICKS) + 1,
  parameter int unsigned MAX_CLICKS   = 3,
  parameter int unsigned CLICK_BITS   = $clog2(MAX_CLICKS + 1)
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_pulse,
  input  logic                  in_ready,
  output logic                  out_valid,
  output logic [CLICK_BITS-1:0] out_clicks,
  output logic                  out_dropped,
  output logic                  out_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  localparam logic [WINDOW_BITS-1:0] TIMER_ZERO = '0;
  localparam logic [WINDOW_BITS-1:0] TIMER_ONE  = WINDOW_BITS'(1);
  localparam logic [WINDOW_BITS-1:0] TIMER_LAST = WINDOW_BITS'(WINDOW_TICKS - 1);
  localparam logic [CLICK_BITS-1:0]  COUNT_ZERO = '0;
  localparam logic [CLICK_BITS-1:0]  COUNT_ONE  = CLICK_BITS'(1);
  localparam logic [CLICK_BITS-1:0]  COUNT_FULL = CLICK_BITS'(MAX_CLICKS);

  logic [1:0]             state,       state_nxt;
  logic [CLICK_BITS-1:0]  count,       count_nxt;
  logic [WINDOW_BITS-1:0] timer,       timer_nxt;
  logic                   valid_nxt;
  logic [CLICK_BITS-1:0]  clicks_nxt;
  logic                   dropped_nxt;
  logic                   busy_nxt;
  logic [CLICK_BITS-1:0]  count_inc;

  // Count a pulse would produce: a fresh group starts at one. Only used while
  // the count is below MAX_CLICKS, so the increment cannot wrap.
  always_comb begin
    count_inc = COUNT_ONE;
    if (state == S_COUNT) begin
      count_inc = count + COUNT_ONE;
    end
  end

  // Next-state and next-output logic; a pulse beats a same-cycle timeout.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    timer_nxt   = timer;
    valid_nxt   = out_valid;
    clicks_nxt  = out_clicks;
    dropped_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        timer_nxt = TIMER_ZERO;
        if (in_pulse) begin
          count_nxt = count_inc;
          if (count_inc == COUNT_FULL) begin
            state_nxt  = S_EMIT;
            valid_nxt  = 1'b1;
            clicks_nxt = count_inc;
          end else begin
            state_nxt = S_COUNT;
          end
        end
      end

      S_COUNT: begin
        if (in_pulse) begin
          count_nxt = count_inc;
          timer_nxt = TIMER_ZERO;
          if (count_inc == COUNT_FULL) begin
            state_nxt  = S_EMIT;
            valid_nxt  = 1'b1;
            clicks_nxt = count_inc;
          end
        end else if (timer == TIMER_LAST) begin
          state_nxt  = S_EMIT;
          timer_nxt  = TIMER_ZERO;
          valid_nxt  = 1'b1;
          clicks_nxt = count;
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end

      S_EMIT: begin
        timer_nxt   = TIMER_ZERO;
        dropped_nxt = in_pulse;
        if (out_valid && in_ready) begin
          state_nxt  = S_IDLE;
          count_nxt  = COUNT_ZERO;
          valid_nxt  = 1'b0;
          clicks_nxt = COUNT_ZERO;
        end
      end

      default: begin
        state_nxt  = S_IDLE;
        count_nxt  = COUNT_ZERO;
        timer_nxt  = TIMER_ZERO;
        valid_nxt  = 1'b0;
        clicks_nxt = COUNT_ZERO;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State, counters and all outputs; reset drops any group or pending event.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state       <= S_IDLE;
      count       <= COUNT_ZERO;
      timer       <= TIMER_ZERO;
      out_valid   <= 1'b0;
      out_clicks  <= COUNT_ZERO;
      out_dropped <= 1'b0;
      out_busy    <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      timer       <= timer_nxt;
      out_valid   <= valid_nxt;
      out_clicks  <= clicks_nxt;
      out_dropped <= dropped_nxt;
      out_busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_button_click_classifier.sv
// Bench for button_click_classifier: directed scenarios with literal
// expectations plus a randomized run, all checked against a time-based model.
module tb_button_click_classifier;

  localparam int unsigned W  = 8;
  localparam int unsigned M  = 3;
  localparam int unsigned WB = $clog2(W) + 1;
  localparam int unsigned CB = $clog2(M + 1);

  logic          in_clk   = 1'b0;
  logic          in_rst   = 1'b0;
  logic          in_pulse = 1'b0;
  logic          in_ready = 1'b1;
  logic          out_valid;
  logic [CB-1:0] out_clicks;
  logic          out_dropped;
  logic          out_busy;

  button_click_classifier #(
    .WINDOW_TICKS(W),
    .WINDOW_BITS (WB),
    .MAX_CLICKS  (M),
    .CLICK_BITS  (CB)
  ) dut (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_pulse   (in_pulse),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_clicks (out_clicks),
    .out_dropped(out_dropped),
    .out_busy   (out_busy)
  );

  always #5 in_clk = ~in_clk;

  int errors = 0;
  int checks = 0;

  // Model state: edge number, open group size and time of its last pulse,
  // pending event and its click count, drop flag for the cycle after an edge.
  int n     = 0;
  int grp   = 0;
  int last  = 0;
  bit pend  = 1'b0;
  int pclk  = 0;
  bit mdrop = 1'b0;

  // Observed events (edge number, clicks) and drops, logged from DUT outputs.
  int ev_edge[$];
  int ev_clk[$];
  int ev_drops = 0;
  bit pv = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  // Reference model: groups close when W cycles pass after the last pulse
  // or when M pulses have been seen; pulses during a pending event are lost.
  initial forever begin
    @(posedge in_clk or negedge in_rst);
    if (!in_rst) begin
      grp = 0; pend = 1'b0; pclk = 0; mdrop = 1'b0;
    end else begin
      n++;
      mdrop = 1'b0;
      if (pend) begin
        if (in_pulse) mdrop = 1'b1;
        if (in_ready) begin pend = 1'b0; pclk = 0; end
      end else if (grp > 0) begin
        if (in_pulse) begin
          grp++; last = n;
          if (grp == M) begin pend = 1'b1; pclk = grp; grp = 0; end
        end else if (n - last >= W) begin
          pend = 1'b1; pclk = grp; grp = 0;
        end
      end else if (in_pulse) begin
        grp = 1; last = n;
        if (grp == M) begin pend = 1'b1; pclk = grp; grp = 0; end
      end
    end
  end

  // Compare DUT outputs against the model every cycle, mid-period.
  initial forever begin
    @(negedge in_clk);
    chk("valid",   int'(out_valid),   int'(pend));
    chk("clicks",  int'(out_clicks),  pend ? pclk : 0);
    chk("dropped", int'(out_dropped), int'(mdrop));
    chk("busy",    int'(out_busy),    int'(pend || grp > 0));
    if (out_valid && !pv) begin
      ev_edge.push_back(n);
      ev_clk.push_back(int'(out_clicks));
    end
    if (out_dropped) ev_drops++;
    pv = out_valid;
  end

  task automatic cyc(input logic p, input logic r);
    @(negedge in_clk);
    in_pulse = p;
    in_ready = r;
  endtask

  // Runs len cycles with pulses at the given offsets; base is the edge
  // number that samples offset 0.
  task automatic scen(input int o0, input int o1, input int o2, input int o3,
                      input int len, input logic r, output int base);
    @(posedge in_clk);
    ev_edge.delete();
    ev_clk.delete();
    ev_drops = 0;
    base = 0;
    for (int i = 0; i < len; i++) begin
      cyc((i == o0) || (i == o1) || (i == o2) || (i == o3), r);
      if (i == 0) base = n + 1;
    end
    #1;
  endtask

  task automatic check_events(input string name, input int base, input int exp_n,
                              input int e0, input int c0, input int e1, input int c1,
                              input int exp_drops);
    chk({name, "_events"}, ev_edge.size(), exp_n);
    chk({name, "_drops"}, ev_drops, exp_drops);
    if (exp_n > 0 && ev_edge.size() > 0) begin
      chk({name, "_edge0"}, ev_edge[0] - base, e0);
      chk({name, "_clicks0"}, ev_clk[0], c0);
    end
    if (exp_n > 1 && ev_edge.size() > 1) begin
      chk({name, "_edge1"}, ev_edge[1] - base, e1);
      chk({name, "_clicks1"}, ev_clk[1], c1);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"},   int'(out_valid),   0);
    chk({name, "_clicks"},  int'(out_clicks),  0);
    chk({name, "_dropped"}, int'(out_dropped), 0);
    chk({name, "_busy"},    int'(out_busy),    0);
  endtask

  int base;

  initial begin
    // Pulses while held in reset have no effect.
    repeat (3) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    #1 chk_all_zero("in_reset");
    @(negedge in_clk);
    in_rst = 1'b1;

    scen(-1, -1, -1, -1, 50, 1'b1, base);
    chk("idle_events", ev_edge.size(), 0);

    scen(0, -1, -1, -1, 30, 1'b1, base);
    check_events("single", base, 1, 8, 1, 0, 0, 0);

    scen(0, 5, -1, -1, 30, 1'b1, base);
    check_events("double", base, 1, 13, 2, 0, 0, 0);

    scen(0, 8, -1, -1, 30, 1'b1, base);
    check_events("gap_w", base, 1, 16, 2, 0, 0, 0);

    scen(0, 9, -1, -1, 30, 1'b1, base);
    check_events("gap_w1", base, 1, 8, 1, 0, 0, 1);

    scen(0, 10, -1, -1, 40, 1'b1, base);
    check_events("gap_w2", base, 2, 8, 1, 18, 1, 0);

    // Full group under backpressure, then a fourth pulse that is dropped.
    scen(0, 2, 4, 6, 20, 1'b0, base);
    check_events("max", base, 1, 4, 3, 0, 0, 1);
    chk("max_hold_valid", int'(out_valid), 1);
    chk("max_hold_clicks", int'(out_clicks), 3);
    cyc(1'b0, 1'b1);
    @(negedge in_clk);
    #1;
    chk("max_hs_valid", int'(out_valid), 0);
    chk("max_hs_busy", int'(out_busy), 0);
    repeat (5) cyc(1'b0, 1'b1);

    // Long backpressure, then reset during the hold.
    scen(0, -1, -1, -1, 30, 1'b0, base);
    check_events("bp", base, 1, 8, 1, 0, 0, 0);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_clicks", int'(out_clicks), 1);
    @(negedge in_clk);
    #2 in_rst = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge in_clk);
    in_rst = 1'b1;
    scen(0, -1, -1, -1, 20, 1'b1, base);
    check_events("after_reset", base, 1, 8, 1, 0, 0, 0);

    // Randomized traffic with alternating pulse density and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if (i % 900 == 450) begin
        @(negedge in_clk);
        #2 in_rst = 1'b0;
        @(negedge in_clk);
        in_rst = 1'b1;
      end else if (((i / 500) % 2) == 1) begin
        cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      end else begin
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 1) != 0);
      end
    end
    repeat (20) cyc(1'b0, 1'b1);
    @(negedge in_clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
